// File: rtl/id_issue.sv
// Decode-and-issue stage for RV32I integer-ALU instructions feeding the ex stage.
// Reads/forwards operands and holds the decoded result in a registered ID/EX slot.

package id_issue_pkg;

    localparam int AluSelBus  = 3;
    localparam int AluOpBus   = 8;
    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic [AluSelBus-1:0] EXE_RES_NOP   = 3'b000;
    localparam logic [AluSelBus-1:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [AluSelBus-1:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [AluSelBus-1:0] EXE_RES_ARITH = 3'b100;

    localparam logic [AluOpBus-1:0] EXE_NOP_OP  = 8'h00;
    localparam logic [AluOpBus-1:0] EXE_ADD_OP  = 8'h20;
    localparam logic [AluOpBus-1:0] EXE_SUB_OP  = 8'h22;
    localparam logic [AluOpBus-1:0] EXE_SLT_OP  = 8'h2A;
    localparam logic [AluOpBus-1:0] EXE_SLTU_OP = 8'h2B;
    localparam logic [AluOpBus-1:0] EXE_AND_OP  = 8'h24;
    localparam logic [AluOpBus-1:0] EXE_OR_OP   = 8'h25;
    localparam logic [AluOpBus-1:0] EXE_XOR_OP  = 8'h26;
    localparam logic [AluOpBus-1:0] EXE_SLL_OP  = 8'h7C;
    localparam logic [AluOpBus-1:0] EXE_SRL_OP  = 8'h02;
    localparam logic [AluOpBus-1:0] EXE_SRA_OP  = 8'h03;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic                  valid;
        logic [AluSelBus-1:0]  sel;
        logic [AluOpBus-1:0]   op;
        logic [RegBus-1:0]     v1;
        logic [RegBus-1:0]     v2;
        logic [RegAddrBus-1:0] waddr;
        logic                  we;
        logic                  illegal;
    } slot_t;

endpackage

module id_issue
    import id_issue_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inst_valid_i,
    input  logic [31:0]           inst_i,
    input  logic [31:0]           pc_i,
    output logic                  inst_ready_o,
    output logic [RegAddrBus-1:0] raddr1_o,
    output logic [RegAddrBus-1:0] raddr2_o,
    input  logic [RegBus-1:0]     rdata1_i,
    input  logic [RegBus-1:0]     rdata2_i,
    input  logic                  fwd_we_i,
    input  logic [RegAddrBus-1:0] fwd_waddr_i,
    input  logic [RegBus-1:0]     fwd_wdata_i,
    input  logic                  flush_i,
    input  logic                  ex_ready_i,
    output logic                  ex_valid_o,
    output logic [AluSelBus-1:0]  alusel_o,
    output logic [AluOpBus-1:0]   aluop_o,
    output logic [RegBus-1:0]     opv1_o,
    output logic [RegBus-1:0]     opv2_o,
    output logic [RegAddrBus-1:0] waddr_o,
    output logic                  we_o,
    output logic                  illegal_o
);

    localparam slot_t SLOT_BUBBLE = '0;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [RegAddrBus-1:0] rd;
    logic [RegAddrBus-1:0] rs1;
    logic [RegAddrBus-1:0] rs2;
    logic [RegBus-1:0]     imm_i;
    logic [RegBus-1:0]     imm_u;
    logic [RegBus-1:0]     shamt;

    assign opcode = inst_i[6:0];
    assign rd     = inst_i[11:7];
    assign funct3 = inst_i[14:12];
    assign rs1    = inst_i[19:15];
    assign rs2    = inst_i[24:20];
    assign funct7 = inst_i[31:25];
    assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_u  = {inst_i[31:12], 12'b0};
    assign shamt  = {27'b0, inst_i[24:20]};

    assign raddr1_o = rs1;
    assign raddr2_o = rs2;

    // Forward only a result that ex is actually computing from a live slot.
    logic              fwd_live;
    logic [RegBus-1:0] rs1_val;
    logic [RegBus-1:0] rs2_val;

    assign fwd_live = ex_valid_o && fwd_we_i && (fwd_waddr_i != '0);
    assign rs1_val  = (rs1 == '0) ? '0 :
                      (fwd_live && fwd_waddr_i == rs1) ? fwd_wdata_i : rdata1_i;
    assign rs2_val  = (rs2 == '0) ? '0 :
                      (fwd_live && fwd_waddr_i == rs2) ? fwd_wdata_i : rdata2_i;

    logic                 dec_legal;
    logic [AluSelBus-1:0] dec_sel;
    logic [AluOpBus-1:0]  dec_op;
    logic [RegBus-1:0]    dec_v1;
    logic [RegBus-1:0]    dec_v2;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        dec_legal = 1'b0;
        dec_sel   = EXE_RES_NOP;
        dec_op    = EXE_NOP_OP;
        dec_v1    = '0;
        dec_v2    = '0;

        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                dec_v1 = rs1_val;
                dec_v2 = (opcode == OPC_OP) ? rs2_val : imm_i;
                case (funct3)
                    3'b000: begin dec_sel = EXE_RES_ARITH; dec_op = EXE_ADD_OP;  end
                    3'b001: begin dec_sel = EXE_RES_SHIFT; dec_op = EXE_SLL_OP;  end
                    3'b010: begin dec_sel = EXE_RES_ARITH; dec_op = EXE_SLT_OP;  end
                    3'b011: begin dec_sel = EXE_RES_ARITH; dec_op = EXE_SLTU_OP; end
                    3'b100: begin dec_sel = EXE_RES_LOGIC; dec_op = EXE_XOR_OP;  end
                    3'b101: begin dec_sel = EXE_RES_SHIFT; dec_op = EXE_SRL_OP;  end
                    3'b110: begin dec_sel = EXE_RES_LOGIC; dec_op = EXE_OR_OP;   end
                    default: begin dec_sel = EXE_RES_LOGIC; dec_op = EXE_AND_OP; end
                endcase

                if (opcode == OPC_OP) begin
                    if (funct7 == F7_BASE) begin
                        dec_legal = 1'b1;
                    end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                        dec_legal = 1'b1;
                        dec_op    = EXE_SUB_OP;
                    end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                        dec_legal = 1'b1;
                        dec_op    = EXE_SRA_OP;
                    end
                end else begin
                    // Immediate shifts carry funct7 in the upper immediate bits.
                    if (funct3 == 3'b001) begin
                        dec_v2    = shamt;
                        dec_legal = (funct7 == F7_BASE);
                    end else if (funct3 == 3'b101) begin
                        dec_v2    = shamt;
                        dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                        if (funct7 == F7_ALT) begin
                            dec_op = EXE_SRA_OP;
                        end
                    end else begin
                        dec_legal = 1'b1;
                    end
                end
            end
            OPC_LUI: begin
                dec_legal = 1'b1;
                dec_sel   = EXE_RES_ARITH;
                dec_op    = EXE_ADD_OP;
                dec_v2    = imm_u;
            end
            OPC_AUIPC: begin
                dec_legal = 1'b1;
                dec_sel   = EXE_RES_ARITH;
                dec_op    = EXE_ADD_OP;
                dec_v1    = pc_i;
                dec_v2    = imm_u;
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    logic  accept;
    slot_t slot_q;
    slot_t slot_d;

    assign inst_ready_o = flush_i | ~slot_q.valid | ex_ready_i;
    assign accept       = inst_valid_i & inst_ready_o;

    // A flush wins over everything; an accepted illegal word becomes a bubble plus pulse.
    always_comb begin
        slot_d         = slot_q;
        slot_d.illegal = 1'b0;
        if (flush_i) begin
            slot_d = SLOT_BUBBLE;
        end else if (accept && dec_legal) begin
            slot_d.valid   = 1'b1;
            slot_d.sel     = dec_sel;
            slot_d.op      = dec_op;
            slot_d.v1      = dec_v1;
            slot_d.v2      = dec_v2;
            slot_d.waddr   = rd;
            slot_d.we      = (rd != '0);
        end else if (accept) begin
            slot_d         = SLOT_BUBBLE;
            slot_d.illegal = 1'b1;
        end else if (ex_ready_i) begin
            slot_d = SLOT_BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= SLOT_BUBBLE;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            slot_q <= slot_d;
        end
    end

    assign ex_valid_o = slot_q.valid;
    assign alusel_o   = slot_q.sel;
    assign aluop_o    = slot_q.op;
    assign opv1_o     = slot_q.v1;
    assign opv2_o     = slot_q.v2;
    assign waddr_o    = slot_q.waddr;
    assign we_o       = slot_q.we;
    assign illegal_o  = slot_q.illegal;

endmodule

// File: tb/tb_id_issue.sv
// Self-checking bench for id_issue: table-driven single-issue vectors through a
// scoreboard queue, plus hand-written stall, flush and reset sequences.

module tb_id_issue;

    localparam logic [2:0] S_NOP = 3'b000, S_LOG = 3'b001, S_SHF = 3'b010, S_ARI = 3'b100;
    localparam logic [7:0] O_ADD = 8'h20, O_SUB = 8'h22, O_SLT = 8'h2A, O_SLTU = 8'h2B;
    localparam logic [7:0] O_AND = 8'h24, O_XOR = 8'h26, O_SRL = 8'h02, O_SRA = 8'h03;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid_i = 1'b0;
    logic [31:0] inst_i = '0;
    logic [31:0] pc_i = '0;
    logic        inst_ready_o;
    logic [4:0]  raddr1_o, raddr2_o;
    logic [31:0] rdata1_i = '0, rdata2_i = '0;
    logic        fwd_we_i = 1'b0;
    logic [4:0]  fwd_waddr_i = '0;
    logic [31:0] fwd_wdata_i = '0;
    logic        flush_i = 1'b0;
    logic        ex_ready_i = 1'b1;
    logic        ex_valid_o;
    logic [2:0]  alusel_o;
    logic [7:0]  aluop_o;
    logic [31:0] opv1_o, opv2_o;
    logic [4:0]  waddr_o;
    logic        we_o;
    logic        illegal_o;

    id_issue dut (
        .clk(clk), .rst_n(rst_n),
        .inst_valid_i(inst_valid_i), .inst_i(inst_i), .pc_i(pc_i),
        .inst_ready_o(inst_ready_o),
        .raddr1_o(raddr1_o), .raddr2_o(raddr2_o),
        .rdata1_i(rdata1_i), .rdata2_i(rdata2_i),
        .fwd_we_i(fwd_we_i), .fwd_waddr_i(fwd_waddr_i), .fwd_wdata_i(fwd_wdata_i),
        .flush_i(flush_i), .ex_ready_i(ex_ready_i),
        .ex_valid_o(ex_valid_o), .alusel_o(alusel_o), .aluop_o(aluop_o),
        .opv1_o(opv1_o), .opv2_o(opv2_o), .waddr_o(waddr_o), .we_o(we_o),
        .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [2:0]  sel;
        logic [7:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [4:0]  waddr;
        logic        we;
        logic        ill;
        logic        full;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        fwe;
        logic [4:0]  fwa;
        logic [31:0] fwd;
        exp_t        e;
    } vec_t;

    exp_t  sb_q[$];
    string nm_q[$];
    vec_t  vecs[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t slot(input logic [2:0] sel, input logic [7:0] op,
                                  input logic [31:0] v1, input logic [31:0] v2,
                                  input logic [4:0] wa, input logic we);
        exp_t e;
        e.valid = 1'b1; e.sel = sel; e.op = op; e.v1 = v1; e.v2 = v2;
        e.waddr = wa; e.we = we; e.ill = 1'b0; e.full = 1'b1;
        return e;
    endfunction

    function automatic exp_t bub(input logic ill);
        exp_t e;
        e.valid = 1'b0; e.sel = S_NOP; e.op = '0; e.v1 = '0; e.v2 = '0;
        e.waddr = '0; e.we = 1'b0; e.ill = ill; e.full = 1'b0;
        return e;
    endfunction

    function automatic vec_t mk(input string name, input logic [31:0] inst, input logic [31:0] pc,
                                input logic [31:0] rd1, input logic [31:0] rd2, input logic fwe,
                                input logic [4:0] fwa, input logic [31:0] fwd, input exp_t e);
        vec_t v;
        v.name = name; v.inst = inst; v.pc = pc; v.rd1 = rd1; v.rd2 = rd2;
        v.fwe = fwe; v.fwa = fwa; v.fwd = fwd; v.e = e;
        return v;
    endfunction

    task automatic compare_slot();
        exp_t  e;
        string nm;
        if (sb_q.size() == 0) begin
            check("scoreboard_underflow", 32'd1, 32'd0);
            return;
        end
        e  = sb_q.pop_front();
        nm = nm_q.pop_front();
        check({nm, ".valid"},   ex_valid_o, e.valid);
        check({nm, ".alusel"},  alusel_o,   e.sel);
        check({nm, ".we"},      we_o,       e.we);
        check({nm, ".illegal"}, illegal_o,  e.ill);
        if (e.full) begin
            check({nm, ".aluop"}, aluop_o, e.op);
            check({nm, ".opv1"},  opv1_o,  e.v1);
            check({nm, ".opv2"},  opv2_o,  e.v2);
            check({nm, ".waddr"}, waddr_o, e.waddr);
        end
    endtask

    task automatic expect_edge(input string nm, input exp_t e);
        sb_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
        compare_slot();
    endtask

    task automatic issue(input vec_t v);
        logic [31:0] w;
        @(negedge clk);
        inst_valid_i = 1'b1; inst_i = v.inst; pc_i = v.pc;
        rdata1_i = v.rd1; rdata2_i = v.rd2;
        fwd_we_i = v.fwe; fwd_waddr_i = v.fwa; fwd_wdata_i = v.fwd;
        flush_i = 1'b0; ex_ready_i = 1'b1;
        #1;
        w = v.inst;
        check({v.name, ".raddr1"}, raddr1_o, w[19:15]);
        check({v.name, ".raddr2"}, raddr2_o, w[24:20]);
        expect_edge(v.name, v.e);
    endtask

    task automatic check_zero_outputs(input string nm);
        check({nm, ".valid"},   ex_valid_o, 32'd0);
        check({nm, ".we"},      we_o,       32'd0);
        check({nm, ".illegal"}, illegal_o,  32'd0);
        check({nm, ".alusel"},  alusel_o,   32'd0);
        check({nm, ".aluop"},   aluop_o,    32'd0);
        check({nm, ".opv1"},    opv1_o,     32'd0);
        check({nm, ".opv2"},    opv2_o,     32'd0);
        check({nm, ".waddr"},   waddr_o,    32'd0);
    endtask

    localparam logic [31:0] ADDI_X1_5  = 32'h00500093;
    localparam logic [31:0] ADD_X2_X1  = 32'h00108133;
    localparam logic [31:0] FENCE      = 32'h0000000F;
    localparam logic [31:0] ADD_X15_X1 = 32'h001087B3;

    initial begin
        vecs.push_back(mk("addi_x1_5", ADDI_X1_5, 32'h0, 32'hDEAD, 32'h0, 1'b0, 5'd0, 32'h0,
                          slot(S_ARI, O_ADD, 32'h0, 32'h5, 5'd1, 1'b1)));
        vecs.push_back(mk("add_fwd", ADD_X2_X1, 32'h4, 32'h0, 32'h0, 1'b1, 5'd1, 32'h5,
                          slot(S_ARI, O_ADD, 32'h5, 32'h5, 5'd2, 1'b1)));
        vecs.push_back(mk("lui", 32'h123451B7, 32'h8, 32'hFFFFFFFF, 32'h0, 1'b0, 5'd0, 32'h0,
                          slot(S_ARI, O_ADD, 32'h0, 32'h12345000, 5'd3, 1'b1)));
        vecs.push_back(mk("auipc", 32'h00001197, 32'h100, 32'h1234, 32'h0, 1'b0, 5'd0, 32'h0,
                          slot(S_ARI, O_ADD, 32'h100, 32'h1000, 5'd3, 1'b1)));
        vecs.push_back(mk("srai", 32'h40325213, 32'h0, 32'h80000000, 32'h0, 1'b0, 5'd0, 32'h0,
                          slot(S_SHF, O_SRA, 32'h80000000, 32'h3, 5'd4, 1'b1)));
        vecs.push_back(mk("fence_illegal", FENCE, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, bub(1'b1)));
        vecs.push_back(mk("add_x0_nofwd", 32'h00108033, 32'h0, 32'h7, 32'h9, 1'b1, 5'd1, 32'h55,
                          slot(S_ARI, O_ADD, 32'h7, 32'h9, 5'd0, 1'b0)));
        vecs.push_back(mk("sub_fwd_rs1", 32'h407302B3, 32'h0, 32'hA, 32'h3, 1'b1, 5'd6, 32'h99,
                          slot(S_ARI, O_SUB, 32'h99, 32'h3, 5'd5, 1'b1)));
        vecs.push_back(mk("sltiu_m1", 32'hFFF0B413, 32'h0, 32'h1, 32'h0, 1'b0, 5'd0, 32'h0,
                          slot(S_ARI, O_SLTU, 32'h1, 32'hFFFFFFFF, 5'd8, 1'b1)));
        vecs.push_back(mk("slli_bad_f7", 32'h40109493, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, bub(1'b1)));
        vecs.push_back(mk("or_bad_f7", 32'h4020E533, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, bub(1'b1)));
        vecs.push_back(mk("xori_neg", 32'h80014593, 32'h0, 32'h0F0F0F0F, 32'h0, 1'b0, 5'd0, 32'h0,
                          slot(S_LOG, O_XOR, 32'h0F0F0F0F, 32'hFFFFF800, 5'd11, 1'b1)));
        vecs.push_back(mk("srl_fwd_rs2", 32'h0041D633, 32'h0, 32'h80, 32'h1, 1'b1, 5'd4, 32'hABC,
                          slot(S_SHF, O_SRL, 32'h80, 32'hABC, 5'd12, 1'b1)));
        vecs.push_back(mk("and", 32'h0020F6B3, 32'h0, 32'hF0, 32'h3C, 1'b0, 5'd0, 32'h0,
                          slot(S_LOG, O_AND, 32'hF0, 32'h3C, 5'd13, 1'b1)));
        vecs.push_back(mk("slt", 32'h0020A733, 32'h0, 32'h5, 32'h6, 1'b0, 5'd0, 32'h0,
                          slot(S_ARI, O_SLT, 32'h5, 32'h6, 5'd14, 1'b1)));
        vecs.push_back(mk("sra_reg", 32'h4020D833, 32'h0, 32'h80000000, 32'h4, 1'b0, 5'd0, 32'h0,
                          slot(S_SHF, O_SRA, 32'h80000000, 32'h4, 5'd16, 1'b1)));
        vecs.push_back(mk("srli_bad_f7", 32'h0210D893, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, bub(1'b1)));
        vecs.push_back(mk("drain", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, bub(1'b1)));

        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i]);
        end

        // Stall: slot holds ADDI while the next instruction waits three cycles.
        issue(vecs[0]);
        @(negedge clk);
        inst_valid_i = 1'b1; inst_i = ADD_X15_X1; rdata1_i = 32'h2; rdata2_i = 32'h2;
        fwd_we_i = 1'b0; ex_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("stall.inst_ready", inst_ready_o, 32'd0);
            check("stall.valid", ex_valid_o, 32'd1);
            check("stall.alusel", alusel_o, S_ARI);
            check("stall.opv2", opv2_o, 32'h5);
            check("stall.waddr", waddr_o, 32'd1);
            check("stall.we", we_o, 32'd1);
            check("stall.raddr1", raddr1_o, 32'd1);
        end
        @(negedge clk);
        ex_ready_i = 1'b1;
        #1;
        check("release.inst_ready", inst_ready_o, 32'd1);
        expect_edge("release_issue", slot(S_ARI, O_ADD, 32'h2, 32'h2, 5'd15, 1'b1));
        @(negedge clk);
        inst_valid_i = 1'b0;
        expect_edge("release_no_dup", bub(1'b0));

        // Flush with a simultaneous legal instruction, then with an illegal one.
        issue(vecs[0]);
        @(negedge clk);
        flush_i = 1'b1; inst_valid_i = 1'b1; inst_i = ADDI_X1_5; ex_ready_i = 1'b0;
        #1;
        check("flush.inst_ready", inst_ready_o, 32'd1);
        expect_edge("flush_legal", bub(1'b0));
        @(negedge clk);
        inst_i = FENCE;
        expect_edge("flush_illegal", bub(1'b0));
        @(negedge clk);
        flush_i = 1'b0; inst_valid_i = 1'b0; ex_ready_i = 1'b1;
        expect_edge("flush_discarded", bub(1'b0));
        issue(mk("add_after_flush", ADD_X2_X1, 32'h0, 32'h0, 32'h0, 1'b1, 5'd1, 32'h5,
                 slot(S_ARI, O_ADD, 32'h0, 32'h0, 5'd2, 1'b1)));

        // Asynchronous reset while stalled drops the held instruction at once.
        issue(vecs[0]);
        @(negedge clk);
        inst_valid_i = 1'b1; inst_i = ADD_X15_X1; ex_ready_i = 1'b0;
        @(posedge clk);
        #2;
        check("prereset.valid", ex_valid_o, 32'd1);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        @(negedge clk);
        inst_valid_i = 1'b0;
        rst_n = 1'b1;
        expect_edge("post_reset", bub(1'b0));

        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
